apb_req_arbiter: RTL and testbench

// - Shares one APB requester port among NUM_REQ local clients; round-robin arbitration.
// - Runs the APB IDLE/SETUP/ACCESS protocol and drives psel/penable/paddr/pwrite/pwdata.
// - Returns read data and error status to the granted client.
// - Sits between the AHB-side request logic and the APB slave fabric.

---
 rtl/apb_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB requester port among NUM_REQ clients
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    done,
   output logic [DW-1:0]         rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [AW-1:0]         paddr,
   output logic [DW-1:0]         pwdata,
   input  logic                  pready,
   input  logic [DW-1:0]         prdata,
   input  logic                  pslverr
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      ptr, ptr_nxt, cur, cur_nxt;
   logic [IW-1:0]      arb_base, arb_idx;
   logic               arb_hit, start;
   logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
   logic [DW-1:0]      rdata_nxt, pwdata_nxt;
   logic [AW-1:0]      paddr_nxt;
   logic               err_nxt, psel_nxt, penable_nxt, pwrite_nxt;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return sum[IW-1:0];
   endfunction

   // At completion the just-served client becomes lowest priority immediately.
   always_comb begin
      arb_base = (state == ACCESS) ? wrap_inc(cur, 1) : ptr;
      arb_hit  = 1'b0;
      arb_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!arb_hit && req[wrap_inc(arb_base, k)]) begin
            arb_hit = 1'b1;
            arb_idx = wrap_inc(arb_base, k);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      cur_nxt     = cur;
      gnt_nxt     = '0;
      done_nxt    = '0;
      rdata_nxt   = '0;
      err_nxt     = 1'b0;
      psel_nxt    = psel;
      penable_nxt = penable;
      paddr_nxt   = paddr;
      pwrite_nxt  = pwrite;
      pwdata_nxt  = pwdata;
      start       = 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_nxt = tmo_cnt;
`endif
      case (state)
         IDLE: begin
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            start       = arb_hit;
         end
         SETUP: begin
            state_nxt   = ACCESS;
            penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
         end
         ACCESS: begin
            if (pready) begin
               done_nxt[cur] = 1'b1;
               rdata_nxt     = pwrite ? '0 : prdata;
               err_nxt       = pslverr;
               ptr_nxt       = wrap_inc(cur, 1);
               if (arb_hit) begin
                  start = 1'b1;
               end else begin
                  state_nxt   = IDLE;
                  psel_nxt    = 1'b0;
                  penable_nxt = 1'b0;
               end
            end
`ifdef APB_TIMEOUT_EN
            else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               done_nxt[cur] = 1'b1;
               err_nxt       = 1'b1;
               ptr_nxt       = wrap_inc(cur, 1);
               state_nxt     = IDLE;
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
         end
      endcase
      if (start) begin
         state_nxt        = SETUP;
         psel_nxt         = 1'b1;
         penable_nxt      = 1'b0;
         gnt_nxt[arb_idx] = 1'b1;
         cur_nxt          = arb_idx;
         paddr_nxt        = req_addr[arb_idx*AW +: AW];
         pwrite_nxt       = req_write[arb_idx];
         pwdata_nxt       = req_wdata[arb_idx*DW +: DW];
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= IDLE;
         ptr       <= '0;
         cur       <= '0;
         gnt       <= '0;
         done      <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
`ifdef APB_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cur       <= cur_nxt;
         gnt       <= gnt_nxt;
         done      <= done_nxt;
         rsp_rdata <= rdata_nxt;
         rsp_err   <= err_nxt;
         psel      <= psel_nxt;
         penable   <= penable_nxt;
         paddr     <= paddr_nxt;
         pwrite    <= pwrite_nxt;
         pwdata    <= pwdata_nxt;
`ifdef APB_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter (vectors, corner sequences, random vs model)
module tb_apb_req_arbiter;
   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic            pclk = 1'b0;
   logic            presetn;
   logic [N-1:0]    req, req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt, done;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err, psel, penable, pwrite;
   logic [AW-1:0]   paddr;
   logic [DW-1:0]   pwdata;
   logic            pready;
   logic [DW-1:0]   prdata;
   logic            pslverr;

   apb_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
      .prdata(prdata), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int          client;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
      bit          slverr;
      logic [3:0]  exp_gnt;
      logic [3:0]  exp_done;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs[5];
   int   checks = 0;
   int   failures = 0;

   // reference model state (transaction level)
   int              m_owner, m_ptr, m_wait, pick, n;
   bit              m_setup, m_wr, arb;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [N-1:0]    e_gnt, e_done, last_gnt;
   logic [DW-1:0]   e_rdata;
   bit              e_err;
   logic [N-1:0]    p_req, p_write;
   logic [N*AW-1:0] p_addr;
   logic [N*DW-1:0] p_wdata;
   logic            p_pready, p_pslverr;
   logic [DW-1:0]   p_prdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      tick();
      tick();
      presetn = 1'b1;
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic run_xfer(input vec_t v);
      req_write[v.client]         = v.wr;
      req_addr[v.client*AW +: AW]  = v.addr;
      req_wdata[v.client*DW +: DW] = v.wdata;
      req[v.client]               = 1'b1;
      tick();
      chk("vec_gnt", gnt, v.exp_gnt);
      chk("vec_setup_psel", psel, 1);
      chk("vec_setup_penable", penable, 0);
      req[v.client] = 1'b0;
      tick();
      chk("vec_access_penable", penable, 1);
      chk("vec_paddr", paddr, v.addr);
      chk("vec_pwrite", pwrite, v.wr);
      if (v.wr) chk("vec_pwdata", pwdata, v.wdata);
      for (int w = 0; w < v.waits; w++) begin
         pready = 1'b0;
         tick();
         chk("vec_wait_paddr", paddr, v.addr);
         chk("vec_wait_penable", penable, 1);
         chk("vec_wait_done", done, 0);
      end
      pready = 1'b1; prdata = v.rdata; pslverr = v.slverr;
      tick();
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      chk("vec_done", done, v.exp_done);
      chk("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("vec_rsp_err", rsp_err, v.exp_err);
      chk("vec_idle_psel", psel, 0);
   endtask

   initial begin
      vecs[0] = '{client:1, wr:1'b1, addr:32'h10, wdata:32'hA5A5A5A5, waits:0, rdata:32'h0,
                  slverr:1'b0, exp_gnt:4'b0010, exp_done:4'b0010, exp_rdata:32'h0, exp_err:1'b0};
      vecs[1] = '{client:0, wr:1'b0, addr:32'h20, wdata:32'h0, waits:2, rdata:32'hDEADBEEF,
                  slverr:1'b0, exp_gnt:4'b0001, exp_done:4'b0001, exp_rdata:32'hDEADBEEF, exp_err:1'b0};
      vecs[2] = '{client:2, wr:1'b1, addr:32'h30, wdata:32'h01234567, waits:0, rdata:32'h0,
                  slverr:1'b1, exp_gnt:4'b0100, exp_done:4'b0100, exp_rdata:32'h0, exp_err:1'b1};
      vecs[3] = '{client:3, wr:1'b0, addr:32'h44, wdata:32'h0, waits:1, rdata:32'h12345678,
                  slverr:1'b1, exp_gnt:4'b1000, exp_done:4'b1000, exp_rdata:32'h12345678, exp_err:1'b1};
      vecs[4] = '{client:1, wr:1'b1, addr:32'hFFFC, wdata:32'hCAFEF00D, waits:3, rdata:32'hFFFFFFFF,
                  slverr:1'b0, exp_gnt:4'b0010, exp_done:4'b0010, exp_rdata:32'h0, exp_err:1'b0};

      // reset state
      presetn = 1'b0;
      req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      tick();
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_rsp", {rsp_err, rsp_rdata, pwrite}, 0);
      tick();
      presetn = 1'b1;

      for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

      // all clients requesting continuously, zero-wait slave
      do_reset();
      req = 4'hF; pready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         chk("cont_psel", psel, 1);
         chk("cont_penable", penable, (c % 2 == 0));
         chk("cont_gnt", gnt, (c % 2 == 1) ? (1 << (((c - 1) / 2) % N)) : 0);
         chk("cont_done", done, (c % 2 == 1 && c >= 3) ? (1 << (((c - 3) / 2) % N)) : 0);
      end

      // asynchronous reset mid-ACCESS, then priority restarts at client 0
      do_reset();
      req_addr[0 +: AW] = 32'h50; req_write[0] = 1'b0; req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      tick();
      req[3] = 1'b1;
      tick();
      chk("pre_rst_penable", penable, 1);
      presetn = 1'b0;
      #2;
      chk("arst_psel", psel, 0);
      chk("arst_penable", penable, 0);
      chk("arst_paddr", paddr, 0);
      chk("arst_outs", {gnt, done, rsp_err, rsp_rdata}, 0);
      tick();
      presetn = 1'b1;
      req = 4'b1001;
      tick();
      chk("arst_gnt_c0", gnt, 4'b0001);
      chk("arst_no_done", done, 0);
      req[0] = 1'b0; pready = 1'b1;
      tick();
      tick();
      chk("arst_done_c0", done, 4'b0001);
      chk("arst_gnt_c3", gnt, 4'b1000);

      // stuck slave: timeout when enabled, otherwise indefinite wait
      do_reset();
      req_addr[2*AW +: AW] = 32'h60; req_write[2] = 1'b0; req[2] = 1'b1;
      prdata = 32'hBAADF00D;
      tick();
      req[2] = 1'b0;
      tick();
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (done != 0) break;
         if (penable) n++;
         tick();
      end
`ifdef APB_TIMEOUT_EN
      chk("tmo_access_cycles", n, TMO);
      chk("tmo_done", done, 4'b0100);
      chk("tmo_err", rsp_err, 1);
      chk("tmo_rdata", rsp_rdata, 0);
      chk("tmo_psel", psel, 0);
`else
      chk("wait_access_cycles", n, 40);
      chk("wait_no_done", done, 0);
      pready = 1'b1;
      tick();
      chk("wait_done", done, 4'b0100);
      chk("wait_rdata", rsp_rdata, 32'hBAADF00D);
`endif

      // randomized traffic against the transaction-level model
      do_reset();
      m_owner = -1; m_ptr = 0; m_wait = 0; m_setup = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; last_gnt = '0;
      for (int it = 0; it < 1500; it++) begin
         for (int i = 0; i < N; i++) begin
            if (last_gnt[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               req_write[i] = 1'($urandom_range(0, 1));
               req_addr[i*AW +: AW] = $urandom;
               req_wdata[i*DW +: DW] = $urandom;
            end
         end
         pready  = ($urandom_range(0, 9) < 6);
         prdata  = $urandom;
         pslverr = ($urandom_range(0, 7) == 0);
         p_req = req; p_write = req_write; p_addr = req_addr; p_wdata = req_wdata;
         p_pready = pready; p_prdata = prdata; p_pslverr = pslverr;
         tick();

         e_gnt = '0; e_done = '0; e_rdata = '0; e_err = 0; arb = 0;
         if (m_owner < 0) begin
            arb = 1;
         end else if (m_setup) begin
            m_setup = 0;
         end else if (p_pready) begin
            e_done[m_owner] = 1'b1;
            e_rdata = m_wr ? '0 : p_prdata;
            e_err = p_pslverr;
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            arb = 1;
         end else begin
            m_wait++;
`ifdef APB_TIMEOUT_EN
            if (m_wait == TMO) begin
               e_done[m_owner] = 1'b1;
               e_err = 1;
               m_ptr = (m_owner + 1) % N;
               m_owner = -1;
            end
`endif
         end
         if (arb) begin
            pick = rr_pick(p_req, m_ptr);
            if (pick >= 0) begin
               e_gnt[pick] = 1'b1;
               m_owner = pick;
               m_setup = 1;
               m_wait = 0;
               m_wr = p_write[pick];
               m_addr = p_addr[pick*AW +: AW];
               m_wdata = p_wdata[pick*DW +: DW];
            end
         end
         last_gnt = e_gnt;

         chk("rnd_gnt", gnt, e_gnt);
         chk("rnd_done", done, e_done);
         chk("rnd_psel", psel, m_owner >= 0);
         chk("rnd_penable", penable, m_owner >= 0 && !m_setup);
         if (e_done != 0) chk("rnd_rsp", {rsp_err, rsp_rdata}, {e_err, e_rdata});
         if (m_owner >= 0) begin
            chk("rnd_paddr", paddr, m_addr);
            chk("rnd_pwrite", pwrite, m_wr);
            if (m_wr) chk("rnd_pwdata", pwdata, m_wdata);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
